// File: rtl/banked_latency_memory.sv
// Banked bench memory: BANKING_FACTOR-word lines, per-bank write mask, range-checked access.
// Reads return MEM_LATENCY cycles after capture, one per cycle, no backpressure; writes take effect at the edge.
module banked_latency_memory #(
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DEPTH          = 8192,
  parameter int MEM_LATENCY    = 1,
  parameter int INIT_PATTERN   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mem_read_en,
  input  logic                                 mem_write_en,
  input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
  input  logic [BANKING_FACTOR-1:0]            mem_write_mask,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
  output logic                                 mem_resp_valid,
  output logic                                 mem_err
);

  localparam int LW    = BANKING_FACTOR * DATA_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          vld;
    logic          oor;
    logic [LW-1:0] dat;
  } stage_t;

  logic [LW-1:0] mem_q [DEPTH];

  stage_t [MEM_LATENCY-1:0] pipe_q, pipe_d;
  logic [LW-1:0]            resp_dat_q, resp_dat_d;
  logic                     resp_vld_q, resp_vld_d;
  logic                     wr_err_q, wr_err_d;
  logic                     err_q, err_d;

  logic             addr_oor;
  logic [IDX_W-1:0] mem_idx;
  logic [LW-1:0]    rd_line;
  logic [LW-1:0]    wr_line;
  logic             wr_go;

  function automatic logic [LW-1:0] init_line(input int i);
    logic [LW-1:0] l;
    l = '0;
    if (INIT_PATTERN == 1) begin
      for (int k = 0; k < BANKING_FACTOR; k++) begin
        l[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i * BANKING_FACTOR + k);
      end
    end
    return l;
  endfunction

  always_comb begin
    addr_oor = (32'(mem_req_addr) >= 32'(DEPTH));
    mem_idx  = IDX_W'(mem_req_addr);
    rd_line  = addr_oor ? '0 : mem_q[mem_idx];

    // Merge masked banks into the current line; the array itself is written in the ff block.
    wr_line = mem_q[mem_idx];
    for (int k = 0; k < BANKING_FACTOR; k++) begin
      if (mem_write_mask[k]) begin
        wr_line[k*DATA_WIDTH +: DATA_WIDTH] = mem_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    wr_go = mem_write_en && !addr_oor;
  end

  always_comb begin
    pipe_d        = pipe_q;
    pipe_d[0].vld = mem_read_en;
    pipe_d[0].oor = mem_read_en && addr_oor;
    pipe_d[0].dat = mem_read_en ? rd_line : '0;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    resp_vld_d = pipe_q[MEM_LATENCY-1].vld;
    resp_dat_d = pipe_q[MEM_LATENCY-1].vld ? pipe_q[MEM_LATENCY-1].dat : resp_dat_q;
    wr_err_d   = mem_write_en && addr_oor;
    // Write error waits one flop so that with MEM_LATENCY=1 it lands on the read error cycle.
    err_d      = (pipe_q[MEM_LATENCY-1].vld && pipe_q[MEM_LATENCY-1].oor) || wr_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q     <= '0;
      resp_dat_q <= '0;
      resp_vld_q <= 1'b0;
      wr_err_q   <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[IDX_W'(i)] <= init_line(i);
      end
    end else begin
      pipe_q     <= pipe_d;
      resp_dat_q <= resp_dat_d;
      resp_vld_q <= resp_vld_d;
      wr_err_q   <= wr_err_d;
      err_q      <= err_d;
      if (wr_go) begin
        mem_q[mem_idx] <= wr_line;
      end
    end
  end

  assign mem_resp_data  = resp_dat_q;
  assign mem_resp_valid = resp_vld_q;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_banked_latency_memory.sv
// Randomised scoreboard bench for banked_latency_memory (BF=4, LAT=3, DEPTH=512, INIT_PATTERN=1).
module tb_banked_latency_memory;

  localparam int DW    = 16;
  localparam int BF    = 4;
  localparam int AW    = 13;
  localparam int DEPTH = 512;
  localparam int LAT   = 3;
  localparam int LW    = DW * BF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_en = 1'b0;
  logic          mem_write_en = 1'b0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [LW-1:0] mem_req_data = '0;
  logic [BF-1:0] mem_write_mask = '0;
  logic [LW-1:0] mem_resp_data;
  logic          mem_resp_valid;
  logic          mem_err;

  banked_latency_memory #(
    .DATA_WIDTH(DW), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(AW),
    .DEPTH(DEPTH), .MEM_LATENCY(LAT), .INIT_PATTERN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_write_mask(mem_write_mask),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [LW-1:0] dat;
  } exp_t;

  exp_t          sb[$];
  bit            exp_err[int];
  bit            rst_at[int];
  logic [LW-1:0] mem_m [DEPTH];
  logic [LW-1:0] last_data = '0;
  int            edges = 0;
  int            checks = 0;
  int            failures = 0;
  bit            mon_on = 1'b0;

  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h want %h", name, edges, act, exp);
    end
  endtask

  // Line i, word k of the reset image holds i*BF+k.
  task automatic model_reset();
    foreach (mem_m[i]) begin
      for (int k = 0; k < BF; k++) mem_m[i][k*DW +: DW] = DW'(i * BF + k);
    end
  endtask

  // Drive one request cycle; expectations are keyed by the edge that samples it.
  task automatic step(input bit r, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] d, input logic [BF-1:0] m);
    int  e;
    bit  oor;
    exp_t x;
    e   = edges + 1;
    oor = (int'(a) >= DEPTH);
    rst = r; mem_read_en = rd; mem_write_en = wr;
    mem_req_addr = a; mem_req_data = d; mem_write_mask = m;
    if (r) begin
      model_reset();
      while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
      for (int k = e; k <= e + LAT + 1; k++) exp_err.delete(k);
      rst_at[e] = 1'b1;
    end else begin
      if (rd) begin
        x.due = e + LAT;
        x.dat = oor ? '0 : mem_m[9'(a)];
        sb.push_back(x);
        if (oor) exp_err[e + LAT] = 1'b1;
      end
      if (wr) begin
        if (oor) exp_err[e + 1] = 1'b1;
        else begin
          for (int k = 0; k < BF; k++)
            if (m[k]) mem_m[9'(a)][k*DW +: DW] = d[k*DW +: DW];
        end
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    int en;
    en = edges;
    if (mon_on) begin
      if (rst_at.exists(en)) begin
        last_data = '0;
        rst_at.delete(en);
      end
      while (sb.size() > 0 && sb[0].due < en) begin
        chk("resp_missing", LW'(0), LW'(1));
        void'(sb.pop_front());
      end
      if (mem_resp_valid === 1'b1) begin
        if (sb.size() == 0 || sb[0].due != en) begin
          chk("resp_unexpected", LW'(1), LW'(0));
        end else begin
          chk("resp_data", mem_resp_data, sb[0].dat);
          last_data = sb[0].dat;
          void'(sb.pop_front());
        end
      end else begin
        chk("resp_valid", LW'(mem_resp_valid), LW'(0));
        chk("resp_hold", mem_resp_data, last_data);
      end
      chk("mem_err", LW'(mem_err), LW'(exp_err.exists(en)));
      exp_err.delete(en);
    end
  end

  initial begin
    int r;
    logic [AW-1:0] a;
    @(negedge clk);
    step(1, 0, 0, '0, '0, '0);
    step(1, 0, 0, '0, '0, '0);
    mon_on = 1'b1;

    // Reset image read: line 0x100 = {0403,0402,0401,0400}
    step(0, 1, 0, 13'h100, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    // Masked write then read back
    step(0, 0, 1, 13'h010, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101);
    step(0, 1, 0, 13'h010, '0, '0);
    // Same-cycle read/write then read-after-write, back to back
    step(0, 1, 1, 13'h020, 64'h1111_2222_3333_4444, 4'b1111);
    step(0, 1, 0, 13'h020, '0, '0);
    repeat (LAT + 1) step(0, 0, 0, '0, '0, '0);
    // Out-of-range read, write, and both together; 0x300 aliases 0x100 if bits are dropped
    step(0, 1, 0, 13'h300, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    step(0, 0, 1, 13'h300, 64'hDEAD_BEEF_0BAD_F00D, 4'b1111);
    step(0, 1, 0, 13'h100, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    step(0, 1, 1, 13'h1FFF, 64'h1, 4'b1111);
    step(0, 1, 0, 13'h1FF, '0, '0);
    step(0, 1, 0, 13'h200, '0, '0);
    repeat (LAT + 2) step(0, 0, 0, '0, '0, '0);
    // In-flight reads flushed by reset; a fresh read returns afterwards
    step(0, 1, 0, 13'h005, '0, '0);
    repeat (3) step(1, 1, 0, 13'h006, '0, '0);
    step(0, 1, 0, 13'h007, '0, '0);
    repeat (LAT + 2) step(0, 0, 0, '0, '0, '0);

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0)      a = AW'($urandom_range(0, 15));
      else if (r == 1) a = AW'($urandom_range(500, 520));
      else             a = AW'($urandom);
      if ($urandom_range(0, 199) == 0)
        step(1, 1'($urandom), 1'($urandom), a, '0, '0);
      else
        step(0, 1'($urandom), 1'($urandom), a, {$urandom, $urandom}, BF'($urandom));
    end

    repeat (LAT + 3) step(0, 0, 0, '0, '0, '0);
    chk("drain", LW'(sb.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
